// File: rtl/pit_pkg.sv
// Shared encodings, FSM states and command/bus types for the 8253-style PIT bus master.
package pit_pkg;
  localparam logic       OP_PROG  = 1'b0;
  localparam logic       OP_READ  = 1'b1;
  localparam logic [1:0] RL_LATCH = 2'b00;
  localparam logic [1:0] RL_LSB   = 2'b01;
  localparam logic [1:0] RL_MSB   = 2'b10;
  localparam logic [1:0] RL_WORD  = 2'b11;
  localparam logic [1:0] CW_ADDR  = 2'd3;

  // Phases of one bus cycle
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, DONE} pit_state_t;
  // Command sequencer
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} seq_state_t;

  typedef struct packed {
    logic        op;
    logic [1:0]  ch;
    logic [1:0]  rl;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] count;
  } pit_cmd_t;

  typedef struct packed {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_req_t;

  // Step 0 is always the control/latch word; steps 1..2 move count bytes.
  function automatic bus_req_t step_req(input pit_cmd_t c, input logic [1:0] step);
    bus_req_t r;
    logic     msb;
    r    = '0;
    msb  = (step == 2'd2) || (c.rl == RL_MSB);
    r.addr = CW_ADDR;
    r.data = (c.op == OP_READ) ? {c.ch, 6'b000000} : {c.ch, c.rl, c.mode, c.bcd};
    if (step != 2'd0) begin
      r.addr = c.ch;
      r.rd   = (c.op == OP_READ);
      r.data = msb ? c.count[15:8] : c.count[7:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/pit_bus_cycle.sv
// One SETUP/STROBE/HOLD/GAP peripheral bus cycle; start is taken in IDLE or on the
// final GAP cycle so back-to-back cycles keep exactly GAP idle cycles between them.
module pit_bus_cycle
  import pit_pkg::*;
#(
  parameter int STROBE_LEN = 2,
  parameter int GAP_LEN    = 1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       start,
  input  bus_req_t   req,
  input  logic [7:0] din,
  output logic       done,
  output logic [7:0] rbyte,
  output logic [1:0] addr,
  output logic [7:0] dout,
  output logic       wr,
  output logic       rd
);
  pit_state_t state, state_n;
  logic [3:0] cnt;
  logic       is_rd;
  logic       last_stb;

  assign last_stb = (cnt == 4'(STROBE_LEN - 1));
  assign done     = (state == GAP) && (cnt == 4'(GAP_LEN - 1));
  // Strobes decode straight from the state so an async reset drops them at once.
  assign wr       = (state == STROBE) && !is_rd;
  assign rd       = (state == STROBE) && is_rd;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   state_n = STROBE;
      STROBE:  if (last_stb) state_n = HOLD;
      HOLD:    state_n = GAP;
      GAP:     if (done) state_n = start ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      is_rd <= 1'b0;
      addr  <= '0;
      dout  <= '0;
      rbyte <= '0;
    end else begin
      cnt <= (state_n != state) ? 4'd0 : cnt + 4'd1;
      if (start && (state == IDLE || done)) begin
        is_rd <= req.rd;
        addr  <= req.addr;
        dout  <= req.rd ? 8'h00 : req.data;
      end
      if (state == STROBE && last_stb && is_rd) rbyte <= din;
    end
  end
endmodule

// File: rtl/pit_bus_master.sv
// Accepts program / latch-and-read commands and sequences the bus cycles they need
// through pit_bus_cycle, returning a one-cycle completion with read data.
module pit_bus_master
  import pit_pkg::*;
#(
  parameter int STROBE_LEN = 2,
  parameter int GAP        = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_ch,
  input  logic [1:0]  cmd_rl,
  input  logic [2:0]  cmd_mode,
  input  logic        cmd_bcd,
  input  logic [15:0] cmd_count,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic [1:0]  addr,
  output logic [7:0]  dout,
  output logic        wr,
  output logic        rd,
  input  logic [7:0]  din
);
  seq_state_t  state, state_n;
  pit_cmd_t    cmd;
  bus_req_t    req;
  logic [1:0]  step, last_step, req_step;
  logic [15:0] acc, acc_n;
  logic [7:0]  rbyte;
  logic        err, accept, start, cyc_done, msb;

  assign cmd_ready = (state == S_IDLE) || (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state == S_DONE);
  assign rsp_err   = rsp_valid && err;
  assign last_step = (cmd.rl == RL_WORD) ? 2'd2 : 2'd1;
  // While running, the request on offer is the one that follows the cycle in flight.
  assign req_step  = (state == S_RUN) ? step + 2'd1 : 2'd0;
  assign req       = step_req(cmd, req_step);
  assign msb       = (step == 2'd2) || (cmd.rl == RL_MSB);
  assign acc_n     = msb ? {rbyte, acc[7:0]} : {acc[15:8], rbyte};

  pit_bus_cycle #(.STROBE_LEN(STROBE_LEN), .GAP_LEN(GAP)) u_cycle (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start),
    .req     (req),
    .din     (din),
    .done    (cyc_done),
    .rbyte   (rbyte),
    .addr    (addr),
    .dout    (dout),
    .wr      (wr),
    .rd      (rd)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_n = S_ISSUE;
      S_ISSUE: begin
        if (err) state_n = S_DONE;
        else begin
          start   = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (cyc_done) begin
          if (step == last_step) state_n = S_DONE;
          else                   start   = 1'b1;
        end
      end
      S_DONE:  state_n = accept ? S_ISSUE : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cmd      <= '0;
      step     <= '0;
      acc      <= '0;
      err      <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        cmd  <= {cmd_op, cmd_ch, cmd_rl, cmd_mode, cmd_bcd, cmd_count};
        step <= '0;
        acc  <= '0;
        err  <= (cmd_ch == 2'd3) || (cmd_rl == RL_LATCH);
      end else if (state == S_ISSUE && err) begin
        rsp_data <= '0;
      end else if (state == S_RUN && cyc_done) begin
        step <= step + 2'd1;
        if (cmd.op == OP_READ && step != 2'd0) begin
          acc <= acc_n;
          if (step == last_step) rsp_data <= acc_n;
        end
      end
    end
  end
endmodule
